// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one registered 9->16 sign-extension unit between two requesters.
// Optional per-operand zero-extension override is enabled by defining ZERO_EXT_EN.
module imm_ext_arbiter #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [IN_W-1:0]  req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [IN_W-1:0]  req1_data,
    output logic             req1_ready,
`ifdef ZERO_EXT_EN
    input  logic             req0_zext,
    input  logic             req1_zext,
`endif
    output logic [IN_W-1:0]  se_data_in,
    input  logic [OUT_W-1:0] se_data_out,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [OUT_W-1:0] rsp_data,
    input  logic             rsp_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [IN_W-1:0]   op_reg;
    logic              id_reg;
    logic              last_id;
    logic              grant;
    logic              accept;
`ifdef ZERO_EXT_EN
    logic              zext_reg;
`endif

    // A lone valid wins outright; on a tie the requester that did not win last time goes.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_id;
        else if (req1_valid)
            grant = 1'b1;
        accept = (state == IDLE) && (req0_valid || req1_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = WAIT;
            WAIT: state_nxt = CAPT;
            CAPT: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == IDLE) && req0_valid && !grant;
        req1_ready = (state == IDLE) && req1_valid && grant;
        busy       = (state != IDLE);
        se_data_in = op_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg    <= '0;
            id_reg    <= 1'b0;
            last_id   <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
`ifdef ZERO_EXT_EN
            zext_reg  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_reg  <= grant ? req1_data : req0_data;
                id_reg  <= grant;
                last_id <= grant;
`ifdef ZERO_EXT_EN
                zext_reg <= grant ? req1_zext : req0_zext;
`endif
            end
            if (state == CAPT) begin
                rsp_valid <= 1'b1;
                rsp_id    <= id_reg;
`ifdef ZERO_EXT_EN
                if (zext_reg)
                    rsp_data <= {{(OUT_W-IN_W){1'b0}}, se_data_out[IN_W-1:0]};
                else
                    rsp_data <= se_data_out;
`else
                rsp_data  <= se_data_out;
`endif
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter with a behavioural registered sign-extender attached.
module tb_imm_ext_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [8:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        req0_zext, req1_zext;
    logic [8:0]  se_data_in;
    logic [15:0] se_data_out;
    logic        rsp_valid, rsp_id, rsp_ready, busy;
    logic [15:0] rsp_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_ext_arbiter #(.IN_W(9), .OUT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
`ifdef ZERO_EXT_EN
        .req0_zext(req0_zext), .req1_zext(req1_zext),
`endif
        .se_data_in(se_data_in), .se_data_out(se_data_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    // External shared extender: one registered stage.
    always @(posedge clk or posedge rst) begin
        if (rst) se_data_out <= '0;
        else     se_data_out <= {{7{se_data_in[8]}}, se_data_in};
    end

    typedef struct {
        logic        r0v;
        logic [8:0]  r0d;
        logic        r0z;
        logic        r1v;
        logic [8:0]  r1d;
        logic        r1z;
        logic        exp_id;
        logic [15:0] exp_s;
        logic [15:0] exp_z;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts just after a falling edge with the DUT in IDLE; ends the same way.
    task automatic do_op(input vec_t v, input string tag);
        logic [15:0] exp_data;
`ifdef ZERO_EXT_EN
        exp_data = v.exp_z;
`else
        exp_data = v.exp_s;
`endif
        req0_valid = v.r0v; req0_data = v.r0d; req0_zext = v.r0z;
        req1_valid = v.r1v; req1_data = v.r1d; req1_zext = v.r1z;
        rsp_ready  = 1'b1;
        #1;
        chk({tag, " req0_ready"}, 32'(req0_ready), 32'(v.exp_id == 1'b0));
        chk({tag, " req1_ready"}, 32'(req1_ready), 32'(v.exp_id == 1'b1));
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, " wait busy"}, 32'(busy), 32'd1);
        chk({tag, " wait ready"}, 32'({req0_ready, req1_ready}), 32'd0);
        chk({tag, " se_data_in"}, 32'(se_data_in), 32'(v.exp_id ? v.r1d : v.r0d));
        chk({tag, " wait rsp_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, " capt rsp_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, " rsp_id"}, 32'(rsp_id), 32'(v.exp_id));
        chk({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
        chk({tag, " resp ready"}, 32'({req0_ready, req1_ready}), 32'd0);
        @(negedge clk);
        chk({tag, " done rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " done busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        //          r0v r0d      r0z  r1v r1d      r1z  id  sext      zext-build
        vecs[0]  = '{1, 9'h100, 0,   0, 9'h000, 0,   0, 16'hFF00, 16'hFF00};
        vecs[1]  = '{0, 9'h000, 0,   1, 9'h0FF, 0,   1, 16'h00FF, 16'h00FF};
        vecs[2]  = '{1, 9'h1FF, 0,   1, 9'h001, 0,   0, 16'hFFFF, 16'hFFFF};
        vecs[3]  = '{1, 9'h1FF, 0,   1, 9'h001, 0,   1, 16'h0001, 16'h0001};
        vecs[4]  = '{1, 9'h1FF, 0,   1, 9'h001, 0,   0, 16'hFFFF, 16'hFFFF};
        vecs[5]  = '{1, 9'h1FF, 0,   1, 9'h001, 0,   1, 16'h0001, 16'h0001};
        vecs[6]  = '{1, 9'h000, 0,   0, 9'h1FF, 0,   0, 16'h0000, 16'h0000};
        vecs[7]  = '{0, 9'h1FF, 0,   1, 9'h080, 0,   1, 16'h0080, 16'h0080};
        vecs[8]  = '{1, 9'h100, 1,   0, 9'h000, 0,   0, 16'hFF00, 16'h0100};
        vecs[9]  = '{1, 9'h100, 0,   0, 9'h000, 0,   0, 16'hFF00, 16'hFF00};
        vecs[10] = '{0, 9'h000, 0,   1, 9'h1FF, 1,   1, 16'hFFFF, 16'h01FF};

        rst = 1'b1;
        req0_valid = 0; req0_data = '0; req0_zext = 0;
        req1_valid = 0; req1_data = '0; req1_zext = 0;
        rsp_ready = 0;
        #2;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);
        chk("reset rsp_data", 32'(rsp_data), 32'd0);
        chk("reset se_data_in", 32'(se_data_in), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Reset asserted mid-operation (WAIT) with both requesters pending.
        req0_valid = 1; req0_data = 9'h0AB; req1_valid = 1; req1_data = 9'h011;
        #1;
        chk("rst1 first tie req0_ready", 32'(req0_ready), 32'd1);
        chk("rst1 first tie req1_ready", 32'(req1_ready), 32'd0);
        @(negedge clk);
        chk("rst1 in wait busy", 32'(busy), 32'd1);
        chk("rst1 op captured", 32'(se_data_in), 32'h0AB);
        rst = 1'b1;
        #1;
        chk("rst1 async busy", 32'(busy), 32'd0);
        chk("rst1 async se_data_in", 32'(se_data_in), 32'd0);
        chk("rst1 async rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst1 async rsp_data", 32'(rsp_data), 32'd0);
        chk("rst1 async rsp_id", 32'(rsp_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op('{1, 9'h0AB, 0, 1, 9'h011, 0, 0, 16'h00AB, 16'h00AB}, "rst1 reaccept");

        for (int unsigned i = 0; i < 11; i++)
            do_op(vecs[i], $sformatf("vec%0d", i));

        // Consumer stalls five cycles in RESP, then accepts.
        req0_valid = 0; req1_valid = 1; req1_data = 9'h155; req1_zext = 0;
        rsp_ready = 0;
        @(negedge clk);
        req0_valid = 1; req0_data = 9'h00F; req0_zext = 0;
        @(negedge clk); @(negedge clk);
        for (int unsigned i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d rsp_data", i), 32'(rsp_data), 32'hFF55);
            chk($sformatf("stall%0d rsp_id", i), 32'(rsp_id), 32'd1);
            chk($sformatf("stall%0d ready", i), 32'({req0_ready, req1_ready}), 32'd0);
            chk($sformatf("stall%0d busy", i), 32'(busy), 32'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall release rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stall release busy", 32'(busy), 32'd0);
        chk("stall release rsp_data kept", 32'(rsp_data), 32'hFF55);
        chk("stall next grant req0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        chk("stall next accepted", 32'(busy), 32'd1);
        chk("stall next operand", 32'(se_data_in), 32'h00F);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk); @(negedge clk);
        chk("stall next rsp_data", 32'(rsp_data), 32'h000F);
        chk("stall next rsp_id", 32'(rsp_id), 32'd0);
        @(negedge clk);
        chk("stall next done", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
